serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 115 +++++++++++
 tb/tb_serial_add_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell stepped LSB-first over WIDTH bits.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' input that turns the operation into A-B.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  // Handshake: a request is accepted on a rising edge where start=1 and ready=1.
  // Operands are captured on that edge; start at any other time is dropped.
  // done is high for one cycle once sum/cout/overflow hold the new result.

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  always_comb begin
    fa_s = a_sr[0] ^ b_sr[0] ^ carry;
    fa_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    res_next = res_sr >> 1;
    res_next[WIDTH-1] = fa_s;
  end

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction as A + ~B + 1; cin is not used in that mode.
  always_comb begin
    b_load = sub ? ~b : b;
    c_load = sub ? 1'b1 : cin;
  end
`else
  always_comb begin
    b_load = b;
    c_load = cin;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load;
            carry <= c_load;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          res_sr <= res_next;
          carry  <= fa_c;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB on this edge
            sum      <= res_next;
            cout     <= fa_c;
            overflow <= carry ^ fa_c;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready     = (state == IDLE);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl (WIDTH=8): arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results.
module tb_serial_add_ctrl;
  localparam int W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         ready, busy, done, cout, overflow;
  logic [W-1:0] sum;
  logic [1:0]   dbg_state;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .a(a),
    .b(b),
    .cin(cin),
    .ready(ready),
    .busy(busy),
    .done(done),
    .sum(sum),
    .cout(cout),
    .overflow(overflow),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // reference model: {overflow, cout, sum} from plain arithmetic
  function automatic logic [W+1:0] model_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic ci, input logic sb);
    logic [W-1:0] yy;
    logic         cc;
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         ov;
    yy = sb ? ~y : y;
    cc = sb ? 1'b1 : ci;
    full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
    s = full[W-1:0];
    ov = (x[W-1] == yy[W-1]) && (s[W-1] != x[W-1]);
    return {ov, full[W], s};
  endfunction

  // scoreboard: cycles left in the current operation and the visible result
  logic [W+1:0] exp_q[$];
  int           m_left = 0;
  logic [W+1:0] m_out = '0;
  int           cyc = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_left = 0;
      m_out = '0;
      exp_q.delete();
    end else begin
      cyc++;
      if (m_left == 0) begin
        if (start) begin
`ifdef SERIAL_ADD_SUB_EN
          exp_q.push_back(model_op(a, b, cin, sub));
`else
          exp_q.push_back(model_op(a, b, cin, 1'b0));
`endif
          m_left = W + 1;
        end
      end else begin
        m_left--;
        if (m_left == 1) begin
          if (exp_q.size() > 0) m_out = exp_q.pop_front();
        end
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    chk("flags", {61'd0, ready, busy, done},
        {61'd0, m_left == 0, m_left >= 2, m_left == 1});
    chk("result", {54'd0, overflow, cout, sum}, {54'd0, m_out});
  end

  // driver tasks
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                       input logic sb);
    @(posedge clk); #1;
    a = x; b = y; cin = ci; sub = sb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [W-1:0] es, input logic ec,
                           input logic eo, input int exp_lat);
    int k;
    k = 0;
    while (k < 40) begin
      k++;
      @(posedge clk);
      @(negedge clk);
      if (done) break;
    end
    chk({name, "_latency"}, 64'(k), 64'(exp_lat));
    chk({name, "_sum"}, 64'(sum), 64'(es));
    chk({name, "_cout"}, 64'(cout), 64'(ec));
    chk({name, "_ovf"}, 64'(overflow), 64'(eo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    repeat (3) @(posedge clk);
    #3;
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_sum", {54'd0, overflow, cout, sum}, 64'd0);
    reset_n = 1'b1;

    issue(8'h5A, 8'h3C, 1'b0, 1'b0);
    wait_done("basic", 8'h96, 1'b0, 1'b1, 8);

    issue(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done("ripple1", 8'h00, 1'b1, 1'b0, 8);
    issue(8'h7F, 8'h00, 1'b1, 1'b0);
    wait_done("ripple2", 8'h80, 1'b0, 1'b1, 8);

    // start during RUN is dropped
    issue(8'h01, 8'h02, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    a = 8'hF0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignored", 8'h03, 1'b0, 1'b0, 5);
    repeat (12) @(posedge clk);

    // reset in the middle of an operation
    issue(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_outputs", {58'd0, overflow, cout, sum[3:0]}, 64'd0);
    chk("midrst_sum", 64'(sum), 64'd0);
    chk("midrst_flags", {61'd0, ready, busy, done}, 64'b100);
    @(posedge clk); #3;
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    issue(8'h01, 8'h01, 1'b0, 1'b0);
    wait_done("after_rst", 8'h02, 1'b0, 1'b0, 8);

    // continuous start: one result every W+2 cycles
    @(posedge clk); #1;
    a = 8'h10; b = 8'h20; cin = 1'b0; sub = 1'b0; start = 1'b1;
    wait_done("cont0", 8'h30, 1'b0, 1'b0, 9);
    t0 = cyc;
    for (int i = 0; i < 2; i++) begin
      wait_done("cont", 8'h30, 1'b0, 1'b0, W + 2);
      chk("cont_period", 64'(cyc - t0), 64'(W + 2));
      t0 = cyc;
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);

`ifdef SERIAL_ADD_SUB_EN
    issue(8'h10, 8'h01, 1'b1, 1'b1);
    wait_done("sub1", 8'h0F, 1'b1, 1'b0, 8);
    issue(8'h00, 8'h01, 1'b0, 1'b1);
    wait_done("sub2", 8'hFF, 1'b0, 1'b0, 8);
    sub = 1'b0;
`endif

    // pins on the model itself
    chk("model_add", 64'(model_op(8'h5A, 8'h3C, 1'b0, 1'b0)), 64'h296);
    chk("model_sub", 64'(model_op(8'h00, 8'h01, 1'b0, 1'b1)), 64'h0FF);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
